// File: rtl/hazard_ctrl.sv
// Forwarding and hazard-detection unit for the 5-stage core: forwarding selects,
// load-use hold/bubble, taken-branch flush, memory-busy freeze and saturating perf counters.
module hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int LU_CYCLES = 1,
  parameter int FLUSH_N   = 3,
  parameter int PERF_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_AW-1:0]   rs1_q2,
  input  logic [REG_AW-1:0]   rs2_q2,
  input  logic                use_rs1_q2,
  input  logic                use_rs2_q2,
  input  logic [REG_AW-1:0]   rs1_q3,
  input  logic [REG_AW-1:0]   rs2_q3,
  input  logic [REG_AW-1:0]   rd_q3,
  input  logic                mem_ren_q3,
  input  logic [REG_AW-1:0]   rd_q4,
  input  logic [REG_AW-1:0]   rd_q5,
  input  logic                wr_en_q4,
  input  logic                wr_en_q5,
  input  logic                br_taken_q4,
  input  logic                mem_busy_i,
  input  logic                perf_clr_i,
  output logic [1:0]          fwd_a_o,
  output logic [1:0]          fwd_b_o,
  output logic [1:0]          fwd_st_o,
  output logic                hold_o,
  output logic                bubble_o,
  output logic [FLUSH_N-1:0]  flush_o,
  output logic                freeze_o,
  output logic [PERF_W-1:0]   stall_cnt_o,
  output logic [PERF_W-1:0]   flush_cnt_o
);

  typedef enum logic [0:0] {RUN, LDSTALL} state_t;

  localparam logic [3:0] LU_RELOAD = 4'(LU_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu_hit;
  logic       flush_evt;

  // q4 is the younger producer, so it wins over q5 when both match
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd4,
                                         input logic [REG_AW-1:0] rd5,
                                         input logic              we4,
                                         input logic              we5);
    if (we4 && (rd4 == rs) && (rd4 != '0))
      return 2'b01;
    else if (we5 && (rd5 == rs) && (rd5 != '0))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign fwd_a_o  = fwd_sel(rs1_q3, rd_q4, rd_q5, wr_en_q4, wr_en_q5);
  assign fwd_b_o  = fwd_sel(rs2_q3, rd_q4, rd_q5, wr_en_q4, wr_en_q5);
  assign fwd_st_o = fwd_sel(rs2_q3, rd_q4, rd_q5, wr_en_q4, wr_en_q5);

  assign lu_hit = mem_ren_q3 && (rd_q3 != '0) &&
                  ((use_rs1_q2 && (rs1_q2 == rd_q3)) || (use_rs2_q2 && (rs2_q2 == rd_q3)));

  assign freeze_o = mem_busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // freeze masks every other event and leaves the FSM untouched
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_o    = 1'b0;
    bubble_o  = 1'b0;
    flush_o   = '0;
    flush_evt = 1'b0;
    if (!mem_busy_i) begin
      case (state)
        RUN: begin
          if (br_taken_q4) begin
            flush_o   = '1;
            flush_evt = 1'b1;
          end else if (lu_hit) begin
            hold_o   = 1'b1;
            bubble_o = 1'b1;
            if (LU_CYCLES > 1) begin
              state_nxt = LDSTALL;
              cnt_nxt   = LU_RELOAD;
            end
          end
        end
        LDSTALL: begin
          if (br_taken_q4) begin
            flush_o   = '1;
            flush_evt = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            hold_o   = 1'b1;
            bubble_o = 1'b1;
            if (cnt <= 4'd1) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_o || freeze_o) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (flush_evt)          flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end

endmodule
